// File: rtl/phys_reg_free_list.sv
// Physical register free list for the rename stage: hands out the N lowest free
// registers, reclaims retired registers and reloads branch checkpoints.
`timescale 1ns/1ps
module phys_reg_free_list #(
    parameter int N         = 3,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int PR_W      = $clog2(PHYS_REGS),
    parameter int CNT_W     = $clog2(N + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CNT_W-1:0]      num_dispatched,
    input  logic [N-1:0]          retire_valid,
    input  logic [N*PR_W-1:0]     retire_free_regs,
    input  logic                  restore_valid,
    input  logic [PHYS_REGS-1:0]  free_list_restore,
    output logic [N*PR_W-1:0]     regs_to_use,
    output logic [CNT_W-1:0]      num_regs_available,
    output logic [PHYS_REGS-1:0]  free_list_copy,
    output logic [PHYS_REGS-1:0]  updated_free_list,
    output logic [PR_W:0]         free_count,
    output logic                  fl_error
);

    // Architectural registers start mapped, so only the upper registers are free.
    function automatic logic [PHYS_REGS-1:0] reset_vector();
        logic [PHYS_REGS-1:0] v;
        for (int p = 0; p < PHYS_REGS; p++) begin
            v[p] = (p >= ARCH_REGS);
        end
        return v;
    endfunction

    logic [PHYS_REGS-1:0] free_list_q, free_list_d;
    logic                 fl_error_q, fl_error_d;
    logic [PR_W-1:0]      pick [N];
    logic [PR_W-1:0]      ret_reg [N];
    logic [CNT_W-1:0]     found;
    logic [PR_W:0]        pop_cnt;
    logic [PHYS_REGS-1:0] alloc_mask, free_mask;
    logic                 violation;

    // Ascending scan; found saturates at N and doubles as num_regs_available.
    always_comb begin
        found = '0;
        for (int i = 0; i < N; i++) begin
            pick[i] = '0;
        end
        for (int p = 0; p < PHYS_REGS; p++) begin
            if (free_list_q[p] && (found < CNT_W'(N))) begin
                pick[found] = PR_W'(p);
                found       = found + CNT_W'(1);
            end else begin
                found = found;
            end
        end
    end

    // Popcount of the registered free vector.
    always_comb begin
        pop_cnt = '0;
        for (int p = 0; p < PHYS_REGS; p++) begin
            pop_cnt = pop_cnt + (PR_W+1)'(free_list_q[p]);
        end
    end

    // Unpack the retire slots.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ret_reg[i] = retire_free_regs[i*PR_W +: PR_W];
        end
    end

    // Allocation/free masks, protocol checks and next state.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        violation  = 1'b0;
        for (int i = 0; i < N; i++) begin
            alloc_mask[pick[i]] = alloc_mask[pick[i]] |
                ((CNT_W'(i) < num_dispatched) && (CNT_W'(i) < found));
        end
        // p0 is never reclaimed; a retire naming it is dropped silently.
        for (int i = 0; i < N; i++) begin
            free_mask[ret_reg[i]] = free_mask[ret_reg[i]] |
                (retire_valid[i] && (ret_reg[i] != '0));
            violation = violation |
                (retire_valid[i] && (ret_reg[i] != '0) && free_list_q[ret_reg[i]]);
            for (int j = 0; j < i; j++) begin
                violation = violation | (retire_valid[i] && retire_valid[j] &&
                    (ret_reg[i] != '0) && (ret_reg[j] == ret_reg[i]));
            end
        end
        if (restore_valid) begin
            free_list_d = free_list_restore | free_mask;
        end else begin
            free_list_d = (free_list_q & ~alloc_mask) | free_mask;
            violation   = violation | (num_dispatched > found);
        end
        fl_error_d = fl_error_q | violation;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_list_q <= reset_vector();
            fl_error_q  <= 1'b0;
        end else begin
            free_list_q <= free_list_d;
            fl_error_q  <= fl_error_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        assign regs_to_use[g*PR_W +: PR_W] = pick[g];
    end

    assign num_regs_available = found;
    assign free_list_copy     = free_list_q;
    assign updated_free_list  = free_list_d;
    assign free_count         = pop_cnt;
    assign fl_error           = fl_error_q;

endmodule
